// File: rtl/bpu_scoreboard_if.sv
// Issue/writeback/cancel bundle between the BPU decode stage and the hazard scoreboard.
interface bpu_scoreboard_if #(
   parameter int unsigned IDXW = 5,
   parameter int unsigned CNTW = 2
);
   logic            i_flush;
   logic            i_issue_vld;
   logic            i_rs1ren;
   logic [IDXW-1:0] i_rs1idx;
   logic            i_rs2ren;
   logic [IDXW-1:0] i_rs2idx;
   logic            i_rdwen;
   logic [IDXW-1:0] i_rdidx;
   logic            i_wb_vld;
   logic [IDXW-1:0] i_wb_idx;
   logic            i_cancel_vld;
   logic [IDXW-1:0] i_cancel_idx;
   logic                 o_stop;
   logic                 o_issue_ack;
   logic [IDXW+CNTW-1:0] o_pending;
   logic                 o_draining;
   logic                 o_err;

   modport master (
      output i_flush, i_issue_vld, i_rs1ren, i_rs1idx, i_rs2ren, i_rs2idx,
             i_rdwen, i_rdidx, i_wb_vld, i_wb_idx, i_cancel_vld, i_cancel_idx,
      input  o_stop, o_issue_ack, o_pending, o_draining, o_err
   );

   modport slave (
      input  i_flush, i_issue_vld, i_rs1ren, i_rs1idx, i_rs2ren, i_rs2idx,
             i_rdwen, i_rdidx, i_wb_vld, i_wb_idx, i_cancel_vld, i_cancel_idx,
      output o_stop, o_issue_ack, o_pending, o_draining, o_err
   );
endinterface

// File: rtl/bpu_scoreboard.sv
// Per-register pending-write scoreboard: stalls BPU issue on RAW/counter-full hazards
// and holds issue after a flush until all outstanding writes have drained.
module bpu_scoreboard #(
   parameter int unsigned NREG = 32,
   parameter int unsigned IDXW = 5,
   parameter int unsigned CNTW = 2
) (
   input logic          i_clk,
   input logic          i_rst,
   bpu_scoreboard_if.slave bus
);
   localparam int unsigned PW = IDXW + CNTW;
   localparam logic [CNTW-1:0] CNT_MAX = '1;
   localparam logic signed [CNTW+1:0] ONE = (CNTW+2)'(1);

   typedef enum logic {RUN, DRAIN} state_e;

   state_e          state_q;
   logic [CNTW-1:0] cnt_q [NREG];
   logic [CNTW-1:0] cnt_d [NREG];
   logic [PW-1:0]   pend_q, pend_d;
   logic            err_q, err_d;
   logic            haz1, haz2, full, stop, ack;
   logic signed [CNTW+1:0] nxt;

   always_comb begin
      haz1 = bus.i_rs1ren && (bus.i_rs1idx != '0) && (cnt_q[bus.i_rs1idx] != '0);
      haz2 = bus.i_rs2ren && (bus.i_rs2idx != '0) && (cnt_q[bus.i_rs2idx] != '0);
      full = bus.i_rdwen && (bus.i_rdidx != '0) && (cnt_q[bus.i_rdidx] == CNT_MAX);
      stop = bus.i_issue_vld && (haz1 || haz2 || full || (state_q == DRAIN) || bus.i_flush);
      ack  = bus.i_issue_vld && !stop;
   end

   // Issue, writeback and cancel are summed per register in a 2-bit-wider signed
   // temporary so -2..+1 net deltas saturate in one step.
   always_comb begin
      err_d    = err_q;
      pend_d   = '0;
      nxt      = '0;
      cnt_d[0] = '0;
      for (int unsigned r = 1; r < NREG; r++) begin
         nxt = signed'({2'b00, cnt_q[r]});
         if (ack && bus.i_rdwen && (bus.i_rdidx == IDXW'(r)))
            nxt = nxt + ONE;
         if (bus.i_wb_vld && (bus.i_wb_idx == IDXW'(r)))
            nxt = nxt - ONE;
         if (bus.i_cancel_vld && (bus.i_cancel_idx == IDXW'(r)))
            nxt = nxt - ONE;
         if (nxt[CNTW+1]) begin
            cnt_d[r] = '0;
            err_d    = 1'b1;
         end else if (nxt[CNTW]) begin
            cnt_d[r] = CNT_MAX;
            err_d    = 1'b1;
         end else begin
            cnt_d[r] = nxt[CNTW-1:0];
         end
         pend_d = pend_d + PW'(cnt_d[r]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= RUN;
         pend_q  <= '0;
         err_q   <= 1'b0;
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= '0;
      end else begin
         pend_q <= pend_d;
         err_q  <= err_d;
         for (int unsigned r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
         case (state_q)
            RUN:     if (bus.i_flush && (pend_d != '0)) state_q <= DRAIN;
            DRAIN:   if (pend_q == '0) state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.o_stop      = stop;
   assign bus.o_issue_ack = ack;
   assign bus.o_pending   = pend_q;
   assign bus.o_draining  = (state_q == DRAIN);
   assign bus.o_err       = err_q;
endmodule

// File: tb/tb_bpu_scoreboard.sv
// Self-checking bench for bpu_scoreboard: a reference model pushes expected per-cycle
// outputs into a queue, compared against captured DUT outputs at the end of each scenario.
module tb_bpu_scoreboard;
   typedef struct {
      bit rst, flush, vld;
      bit r1en; bit [4:0] r1;
      bit r2en; bit [4:0] r2;
      bit rden; bit [4:0] rd;
      bit wb;   bit [4:0] wbi;
      bit cn;   bit [4:0] cni;
   } stim_t;

   typedef struct packed {
      logic       stop;
      logic       ack;
      logic [6:0] pend;
      logic       drain;
      logic       err;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   bpu_scoreboard_if #(.IDXW(5), .CNTW(2)) bus ();

   bpu_scoreboard #(.NREG(32), .IDXW(5), .CNTW(2)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   int   checks = 0;
   int   errors = 0;
   obs_t exp_q[$];
   obs_t obs_q[$];
   obs_t last;

   int m_cnt[32];
   int m_pend  = 0;
   bit m_drain = 1'b0;
   bit m_err   = 1'b0;

   function automatic stim_t idle();
      stim_t s;
      s = '{default: 0};
      return s;
   endfunction

   task automatic drive(input stim_t s);
      obs_t e, o;
      int   nc[32];
      int   sum;
      bit   h1, h2, full, nd;
      @(negedge clk);
      rst              = s.rst;
      bus.i_flush      = s.flush;
      bus.i_issue_vld  = s.vld;
      bus.i_rs1ren     = s.r1en;
      bus.i_rs1idx     = s.r1;
      bus.i_rs2ren     = s.r2en;
      bus.i_rs2idx     = s.r2;
      bus.i_rdwen      = s.rden;
      bus.i_rdidx      = s.rd;
      bus.i_wb_vld     = s.wb;
      bus.i_wb_idx     = s.wbi;
      bus.i_cancel_vld = s.cn;
      bus.i_cancel_idx = s.cni;
      h1     = s.r1en && s.r1 != 0 && m_cnt[s.r1] != 0;
      h2     = s.r2en && s.r2 != 0 && m_cnt[s.r2] != 0;
      full   = s.rden && s.rd != 0 && m_cnt[s.rd] == 3;
      e.stop = s.vld && (h1 || h2 || full || m_drain || s.flush);
      e.ack  = s.vld && !e.stop;
      nc = m_cnt;
      if (e.ack && s.rden && s.rd != 0) nc[s.rd] = nc[s.rd] + 1;
      if (s.wb && s.wbi != 0) nc[s.wbi] = nc[s.wbi] - 1;
      if (s.cn && s.cni != 0) nc[s.cni] = nc[s.cni] - 1;
      sum = 0;
      for (int i = 0; i < 32; i++) begin
         if (nc[i] < 0) begin nc[i] = 0; m_err = 1'b1; end
         if (nc[i] > 3) begin nc[i] = 3; m_err = 1'b1; end
         sum += nc[i];
      end
      nd = m_drain ? (m_pend != 0) : (s.flush && sum != 0);
      if (s.rst) begin
         for (int i = 0; i < 32; i++) nc[i] = 0;
         sum = 0; nd = 1'b0; m_err = 1'b0;
      end
      m_cnt = nc; m_pend = sum; m_drain = nd;
      e.pend = 7'(sum); e.drain = nd; e.err = m_err;
      exp_q.push_back(e);
      #1;
      o.stop = bus.o_stop;
      o.ack  = bus.o_issue_ack;
      @(posedge clk);
      #1;
      o.pend  = bus.o_pending;
      o.drain = bus.o_draining;
      o.err   = bus.o_err;
      obs_q.push_back(o);
      last = o;
   endtask

   task automatic test_reset();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.rst = 1'b1;
      drive(s);
      drive(s);
      checks++;
      if (last.pend !== 7'd0 || last.drain !== 1'b0 || last.err !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: got pend=%0d drain=%b err=%b want 0 0 0", last.pend, last.drain, last.err);
      end
      s = idle(); s.vld = 1'b1; s.r1en = 1'b1; s.r1 = 5'd3;
      drive(s);
      checks++;
      if (last.stop !== 1'b0 || last.ack !== 1'b1) begin
         errors++;
         $display("FAIL reset_issue: got stop=%b ack=%b want 0 1", last.stop, last.ack);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL reset_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_raw();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'd5;
      drive(s);
      checks++;
      if (last.ack !== 1'b1 || last.pend !== 7'd1) begin
         errors++;
         $display("FAIL raw_issue: got ack=%b pend=%0d want 1 1", last.ack, last.pend);
      end
      s = idle(); s.vld = 1'b1; s.r1en = 1'b1; s.r1 = 5'd5; s.wb = 1'b1; s.wbi = 5'd5;
      drive(s);
      checks++;
      if (last.stop !== 1'b1 || last.pend !== 7'd0) begin
         errors++;
         $display("FAIL raw_stall: got stop=%b pend=%0d want 1 0", last.stop, last.pend);
      end
      s = idle(); s.vld = 1'b1; s.r1en = 1'b1; s.r1 = 5'd5;
      drive(s);
      checks++;
      if (last.stop !== 1'b0 || last.ack !== 1'b1) begin
         errors++;
         $display("FAIL raw_release: got stop=%b ack=%b want 0 1", last.stop, last.ack);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL raw_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_x0_overlap();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'd0;
      drive(s);
      checks++;
      if (last.ack !== 1'b1 || last.pend !== 7'd0) begin
         errors++;
         $display("FAIL x0_write: got ack=%b pend=%0d want 1 0", last.ack, last.pend);
      end
      s = idle(); s.vld = 1'b1; s.r2en = 1'b1; s.r2 = 5'd0; s.rden = 1'b1; s.rd = 5'd7;
      drive(s);
      checks++;
      if (last.stop !== 1'b0 || last.pend !== 7'd1) begin
         errors++;
         $display("FAIL x0_read: got stop=%b pend=%0d want 0 1", last.stop, last.pend);
      end
      s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'd7; s.wb = 1'b1; s.wbi = 5'd7;
      drive(s);
      checks++;
      if (last.ack !== 1'b1 || last.pend !== 7'd1) begin
         errors++;
         $display("FAIL overlap_issue_wb: got ack=%b pend=%0d want 1 1", last.ack, last.pend);
      end
      s = idle(); s.wb = 1'b1; s.wbi = 5'd7;
      drive(s);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL x0_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_saturation();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'd9;
      for (int i = 0; i < 3; i++) drive(s);
      checks++;
      if (last.pend !== 7'd3) begin
         errors++;
         $display("FAIL sat_fill: got pend=%0d want 3", last.pend);
      end
      drive(s);
      checks++;
      if (last.stop !== 1'b1 || last.pend !== 7'd3 || last.err !== 1'b0) begin
         errors++;
         $display("FAIL sat_full: got stop=%b pend=%0d err=%b want 1 3 0", last.stop, last.pend, last.err);
      end
      s = idle(); s.wb = 1'b1; s.wbi = 5'd9;
      for (int i = 0; i < 3; i++) drive(s);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL sat_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_flush_drain();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.vld = 1'b1; s.flush = 1'b1;
      drive(s);
      checks++;
      if (last.stop !== 1'b1 || last.drain !== 1'b0) begin
         errors++;
         $display("FAIL flush_empty: got stop=%b drain=%b want 1 0", last.stop, last.drain);
      end
      s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'd3;
      drive(s);
      s.rd = 5'd4;
      drive(s);
      s = idle(); s.vld = 1'b1; s.flush = 1'b1;
      drive(s);
      checks++;
      if (last.stop !== 1'b1 || last.drain !== 1'b1 || last.pend !== 7'd2) begin
         errors++;
         $display("FAIL flush_enter: got stop=%b drain=%b pend=%0d want 1 1 2", last.stop, last.drain, last.pend);
      end
      s = idle(); s.vld = 1'b1; s.r1en = 1'b1; s.r1 = 5'd11;
      drive(s);
      checks++;
      if (last.stop !== 1'b1) begin
         errors++;
         $display("FAIL drain_hold: got stop=%b want 1", last.stop);
      end
      s = idle(); s.flush = 1'b1; s.wb = 1'b1; s.wbi = 5'd3; s.cn = 1'b1; s.cni = 5'd4;
      drive(s);
      checks++;
      if (last.pend !== 7'd0 || last.drain !== 1'b1) begin
         errors++;
         $display("FAIL drain_empty: got pend=%0d drain=%b want 0 1", last.pend, last.drain);
      end
      s = idle(); s.vld = 1'b1;
      drive(s);
      checks++;
      if (last.drain !== 1'b0) begin
         errors++;
         $display("FAIL drain_exit: got drain=%b want 0", last.drain);
      end
      drive(s);
      checks++;
      if (last.stop !== 1'b0 || last.ack !== 1'b1) begin
         errors++;
         $display("FAIL run_issue: got stop=%b ack=%b want 0 1", last.stop, last.ack);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL flush_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_underflow();
      stim_t s;
      obs_t  e, o;
      s = idle(); s.wb = 1'b1; s.wbi = 5'd12;
      drive(s);
      checks++;
      if (last.pend !== 7'd0 || last.err !== 1'b1) begin
         errors++;
         $display("FAIL underflow: got pend=%0d err=%b want 0 1", last.pend, last.err);
      end
      s = idle();
      drive(s);
      drive(s);
      checks++;
      if (last.err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got err=%b want 1", last.err);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL underflow_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_reset_mid_drain();
      stim_t s;
      obs_t  e, o;
      for (int i = 1; i <= 4; i++) begin
         s = idle(); s.vld = 1'b1; s.rden = 1'b1; s.rd = 5'(i);
         drive(s);
      end
      s = idle(); s.flush = 1'b1;
      drive(s);
      checks++;
      if (last.pend !== 7'd4 || last.drain !== 1'b1 || last.err !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset: got pend=%0d drain=%b err=%b want 4 1 1", last.pend, last.drain, last.err);
      end
      s = idle(); s.rst = 1'b1; s.vld = 1'b1;
      drive(s);
      checks++;
      if (last.pend !== 7'd0 || last.drain !== 1'b0 || last.err !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: got pend=%0d drain=%b err=%b want 0 0 0", last.pend, last.drain, last.err);
      end
      s = idle(); s.vld = 1'b1; s.r1en = 1'b1; s.r1 = 5'd1;
      drive(s);
      checks++;
      if (last.stop !== 1'b0) begin
         errors++;
         $display("FAIL post_reset_stop: got stop=%b want 0", last.stop);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL rstdrain_sb: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s;
      obs_t  e, o;
      int    n;
      s = idle(); s.rst = 1'b1;
      drive(s);
      for (int i = 0; i < 400; i++) begin
         s       = idle();
         s.vld   = ($urandom_range(0, 3) != 0);
         s.r1en  = $urandom_range(0, 1);
         s.r1    = 5'($urandom_range(0, 7));
         s.r2en  = $urandom_range(0, 1);
         s.r2    = 5'($urandom_range(0, 7));
         s.rden  = ($urandom_range(0, 3) != 0);
         s.rd    = 5'($urandom_range(0, 7));
         s.wb    = ($urandom_range(0, 2) == 0);
         s.wbi   = 5'($urandom_range(0, 7));
         s.cn    = ($urandom_range(0, 7) == 0);
         s.cni   = 5'($urandom_range(0, 7));
         s.flush = ($urandom_range(0, 19) == 0);
         s.rst   = ($urandom_range(0, 99) == 0);
         drive(s);
      end
      n = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); o = obs_q.pop_front(); checks++; n++;
         if (o !== e) begin
            errors++;
            $display("FAIL b2b_sb[%0d]: got stop=%b ack=%b pend=%0d drain=%b err=%b want stop=%b ack=%b pend=%0d drain=%b err=%b",
                     n, o.stop, o.ack, o.pend, o.drain, o.err, e.stop, e.ack, e.pend, e.drain, e.err);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_cnt[i] = 0;
      bus.i_flush = 1'b0; bus.i_issue_vld = 1'b0;
      bus.i_rs1ren = 1'b0; bus.i_rs1idx = '0;
      bus.i_rs2ren = 1'b0; bus.i_rs2idx = '0;
      bus.i_rdwen = 1'b0;  bus.i_rdidx = '0;
      bus.i_wb_vld = 1'b0; bus.i_wb_idx = '0;
      bus.i_cancel_vld = 1'b0; bus.i_cancel_idx = '0;
      test_reset();
      test_raw();
      test_x0_overlap();
      test_saturation();
      test_flush_drain();
      test_underflow();
      test_reset_mid_drain();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
